// File: rtl/flash_boot_copy_if.sv
// Flash read port and RAM write port driven by the boot copier.
// Signal suffixes are from the copier's side.
interface flash_boot_copy_if;
  logic [31:0] fl_adr_o;
  logic        fl_stb_o;
  logic        fl_we_o;
  logic [31:0] fl_dat_i;
  logic        fl_ready_i;
  logic [31:0] ram_adr_o;
  logic [31:0] ram_dat_o;
  logic        ram_stb_o;
  logic        ram_we_o;
  logic        ram_ready_i;

  modport master (
    output fl_adr_o, fl_stb_o, fl_we_o, ram_adr_o, ram_dat_o, ram_stb_o, ram_we_o,
    input  fl_dat_i, fl_ready_i, ram_ready_i
  );

  modport slave (
    input  fl_adr_o, fl_stb_o, fl_we_o, ram_adr_o, ram_dat_o, ram_stb_o, ram_we_o,
    output fl_dat_i, fl_ready_i, ram_ready_i
  );
endinterface

// File: rtl/flash_boot_copy.sv
// Boot copier: moves WORD_COUNT words from flash to RAM one at a time,
// holding the CPU in reset until the image is in place.
module flash_boot_copy #(
  parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
  parameter logic [31:0] DST_BASE   = 32'h0000_0000,
  parameter int          WORD_COUNT = 256,
  parameter int          TIMEOUT    = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cpu_hold_o,
  output logic [31:0] checksum_o,
  flash_boot_copy_if.master bus
);

  localparam int                TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [15:0]       WC_LAST   = 16'(WORD_COUNT - 1);
  localparam logic [31:0]       SRC_ALIGN = {SRC_BASE[31:2], 2'b00};
  localparam logic [31:0]       DST_ALIGN = {DST_BASE[31:2], 2'b00};

  typedef enum logic [2:0] {IDLE, FL_RD, FL_GAP, RAM_WR, RAM_GAP, DONE, ERR} state_t;

  state_t             state_q;
  logic               busy_q, done_q, err_q, cpu_hold_q;
  logic               fl_stb_q, ram_stb_q, ram_we_q;
  logic [31:0]        fl_adr_q, ram_adr_q, ram_dat_q, checksum_q;
  logic [15:0]        cnt_q;
  logic [TMO_W-1:0]   tmo_q;

  logic [31:0]        fl_adr_d, ram_adr_d, checksum_d;
  logic [15:0]        cnt_d;
  logic [TMO_W-1:0]   tmo_d;

  assign fl_adr_d   = fl_adr_q + 32'd4;
  assign ram_adr_d  = ram_adr_q + 32'd4;
  assign checksum_d = checksum_q + bus.fl_dat_i;
  assign cnt_d      = cnt_q + 16'd1;
  assign tmo_d      = tmo_q + TMO_W'(1);

  // Ready inputs are only looked at in the state whose strobe is high,
  // so stray pulses elsewhere fall through untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
      fl_stb_q   <= 1'b0;
      ram_stb_q  <= 1'b0;
      ram_we_q   <= 1'b0;
      fl_adr_q   <= SRC_ALIGN;
      ram_adr_q  <= DST_ALIGN;
      ram_dat_q  <= 32'd0;
      checksum_q <= 32'd0;
      cnt_q      <= 16'd0;
      tmo_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start_i) begin
          state_q    <= FL_RD;
          busy_q     <= 1'b1;
          fl_stb_q   <= 1'b1;
          fl_adr_q   <= SRC_ALIGN;
          ram_adr_q  <= DST_ALIGN;
          cnt_q      <= 16'd0;
          tmo_q      <= '0;
          checksum_q <= 32'd0;
        end
        FL_RD: begin
          if (bus.fl_ready_i) begin
            ram_dat_q  <= bus.fl_dat_i;
            checksum_q <= checksum_d;
            fl_stb_q   <= 1'b0;
            state_q    <= FL_GAP;
          end else if (tmo_q == TMO_LAST) begin
            fl_stb_q <= 1'b0;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ERR;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        FL_GAP: begin
          ram_stb_q <= 1'b1;
          ram_we_q  <= 1'b1;
          tmo_q     <= '0;
          state_q   <= RAM_WR;
        end
        RAM_WR: begin
          if (bus.ram_ready_i) begin
            ram_stb_q <= 1'b0;
            ram_we_q  <= 1'b0;
            state_q   <= RAM_GAP;
          end else if (tmo_q == TMO_LAST) begin
            ram_stb_q <= 1'b0;
            ram_we_q  <= 1'b0;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ERR;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        RAM_GAP: begin
          cnt_q     <= cnt_d;
          fl_adr_q  <= fl_adr_d;
          ram_adr_q <= ram_adr_d;
          if (cnt_q == WC_LAST) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
            state_q    <= DONE;
          end else begin
            fl_stb_q <= 1'b1;
            tmo_q    <= '0;
            state_q  <= FL_RD;
          end
        end
        DONE, ERR: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign cpu_hold_o    = cpu_hold_q;
  assign checksum_o    = checksum_q;
  assign bus.fl_adr_o  = fl_adr_q;
  assign bus.fl_stb_o  = fl_stb_q;
  assign bus.fl_we_o   = 1'b0;
  assign bus.ram_adr_o = ram_adr_q;
  assign bus.ram_dat_o = ram_dat_q;
  assign bus.ram_stb_o = ram_stb_q;
  assign bus.ram_we_o  = ram_we_q;

endmodule
